// File: rtl/tl_a_channel_queue.sv
// tl_a_channel_queue: TileLink-UL A-channel elastic FIFO with
// optional flow-through (FLOW) and pipelined-full (PIPE) modes.
module tl_a_channel_queue #(
  parameter int DEPTH = 2,
  parameter int SRC_W = 1,
  parameter bit FLOW  = 1'b0,
  parameter bit PIPE  = 1'b0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [2:0]                 enq_opcode,
  input  logic [2:0]                 enq_param,
  input  logic [3:0]                 enq_size,
  input  logic [SRC_W-1:0]           enq_source,
  input  logic [29:0]                enq_address,
  input  logic [3:0]                 enq_mask,
  input  logic [31:0]                enq_data,
  input  logic                       enq_corrupt,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [2:0]                 deq_opcode,
  output logic [2:0]                 deq_param,
  output logic [3:0]                 deq_size,
  output logic [SRC_W-1:0]           deq_source,
  output logic [29:0]                deq_address,
  output logic [3:0]                 deq_mask,
  output logic [31:0]                deq_data,
  output logic                       deq_corrupt,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = 3 + 3 + 4 + SRC_W + 30 + 4 + 32 + 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [BW-1:0] ram [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          maybe_full;

  logic [BW-1:0] enq_beat;
  logic [BW-1:0] head_beat;
  logic [BW-1:0] deq_beat;
  logic          ptr_match;
  logic          empty;
  logic          full;
  logic          bypass;
  logic          enq_fire;
  logic          deq_fire;
  logic          do_enq;
  logic          do_deq;
  logic [CW-1:0] diff;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign enq_beat = {
    enq_opcode, enq_param, enq_size,
    enq_source, enq_address, enq_mask,
    enq_data, enq_corrupt
  };

  assign ptr_match = (wptr == rptr);
  assign empty     = ptr_match & ~maybe_full;
  assign full      = ptr_match & maybe_full;
  assign bypass    = FLOW & empty;

  assign enq_ready = reset_n
                   & (~full | (PIPE & deq_ready));

  // flow-through view is masked in reset so no beat leaks out
  assign deq_valid = ~empty
                   | (bypass & reset_n & enq_valid);

  assign head_beat = ram[rptr];
  assign deq_beat  = bypass ? enq_beat : head_beat;

  assign {
    deq_opcode, deq_param, deq_size,
    deq_source, deq_address, deq_mask,
    deq_data, deq_corrupt
  } = deq_beat;

  assign enq_fire = enq_valid & enq_ready;
  assign deq_fire = deq_valid & deq_ready;

  // a bypassed beat never touches storage
  assign do_enq = enq_fire & ~(bypass & deq_ready);
  assign do_deq = deq_fire & ~bypass;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wptr       <= '0;
      rptr       <= '0;
      maybe_full <= 1'b0;
    end else begin
      if (do_enq) wptr <= nxt(wptr);
      if (do_deq) rptr <= nxt(rptr);
      if (do_enq != do_deq) maybe_full <= do_enq;
    end
  end

  always_ff @(posedge clock) begin
    if (do_enq) ram[wptr] <= enq_beat;
  end

  assign diff = (wptr >= rptr)
    ? CW'(wptr) - CW'(rptr)
    : CW'(wptr) + CW'(DEPTH) - CW'(rptr);

  assign count = full ? CW'(DEPTH) : diff;

endmodule

// File: tb/tb_tl_a_channel_queue.sv
// tb_tl_a_channel_queue: four queue variants driven side by side,
// checked against a queue-based reference and a beat scoreboard.
module tb_tl_a_channel_queue;

  localparam int N  = 4;
  localparam int SW = 2;

  typedef struct packed {
    logic [2:0]    opcode;
    logic [2:0]    param;
    logic [3:0]    size;
    logic [SW-1:0] source;
    logic [29:0]   address;
    logic [3:0]    mask;
    logic [31:0]   data;
    logic          corrupt;
  } beat_t;

  function automatic int dep(input int i);
    return (i == 3) ? 3 : 2;
  endfunction

  function automatic bit flw(input int i);
    return i == 2;
  endfunction

  function automatic bit pip(input int i);
    return i == 1;
  endfunction

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ev  [N];
  logic       dr  [N];
  beat_t      eb  [N];
  logic       er  [N];
  logic       dv  [N];
  beat_t      db  [N];
  logic [1:0] cnt [N];

  beat_t sb [N][$];
  bit    fired [N];
  int    pops [N];
  bit    chk_en = 1'b0;
  int    errors = 0;
  int    checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [2:0]    op;
    logic [2:0]    pa;
    logic [3:0]    sz;
    logic [SW-1:0] so;
    logic [29:0]   ad;
    logic [3:0]    mk;
    logic [31:0]   da;
    logic          co;
    logic          r;
    logic          v;
    logic [1:0]    c;

    tl_a_channel_queue #(
      .DEPTH (dep(g)),
      .SRC_W (SW),
      .FLOW  (flw(g)),
      .PIPE  (pip(g))
    ) u_dut (
      .clock       (clk),
      .reset_n     (rst_n),
      .enq_valid   (ev[g]),
      .enq_ready   (r),
      .enq_opcode  (eb[g].opcode),
      .enq_param   (eb[g].param),
      .enq_size    (eb[g].size),
      .enq_source  (eb[g].source),
      .enq_address (eb[g].address),
      .enq_mask    (eb[g].mask),
      .enq_data    (eb[g].data),
      .enq_corrupt (eb[g].corrupt),
      .deq_valid   (v),
      .deq_ready   (dr[g]),
      .deq_opcode  (op),
      .deq_param   (pa),
      .deq_size    (sz),
      .deq_source  (so),
      .deq_address (ad),
      .deq_mask    (mk),
      .deq_data    (da),
      .deq_corrupt (co),
      .count       (c)
    );

    assign er[g]  = r;
    assign dv[g]  = v;
    assign cnt[g] = c;
    assign db[g]  = {op, pa, sz, so, ad, mk, da, co};
  end

  task automatic chk(
    input string        nm,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // reference: occupancy is the scoreboard depth before this edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        int   n;
        logic xr;
        logic xv;
        n  = sb[i].size();
        xr = rst_n && (n < dep(i) || (pip(i) && dr[i]));
        xv = (n > 0) || (flw(i) && rst_n && ev[i]);
        chk($sformatf("u%0d enq_ready", i), er[i], xr);
        chk($sformatf("u%0d deq_valid", i), dv[i], xv);
        chk($sformatf("u%0d count", i), cnt[i], n);
        fired[i] = ev[i] & er[i];
        if (fired[i]) sb[i].push_back(eb[i]);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      #1;
      for (int i = 0; i < N; i++) begin
        if (dv[i] && dr[i]) begin
          if (sb[i].size() == 0) begin
            chk($sformatf("u%0d spurious deq", i), dv[i], 1'b0);
          end else begin
            chk($sformatf("u%0d deq beat", i),
                db[i], sb[i].pop_front());
            pops[i]++;
          end
        end
        if (!rst_n) sb[i].delete();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(
    input bit    v,
    input bit    r,
    input beat_t b
  );
    for (int i = 0; i < N; i++) begin
      ev[i] = v;
      dr[i] = r;
      eb[i] = b;
    end
  endtask

  function automatic beat_t mk(
    input logic [2:0]    op,
    input logic [29:0]   a,
    input logic [31:0]   d,
    input logic [SW-1:0] s
  );
    beat_t b;
    b.opcode  = op;
    b.param   = 3'd0;
    b.size    = 4'd2;
    b.source  = s;
    b.address = a;
    b.mask    = 4'hf;
    b.data    = d;
    b.corrupt = 1'b0;
    return b;
  endfunction

  function automatic beat_t rnd();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[78:0];
  endfunction

  task automatic rand_cycles(input int k);
    for (int c = 0; c < k; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (!ev[i] || fired[i]) begin
          ev[i] = ($urandom_range(0, 3) != 0);
          eb[i] = rnd();
        end
        dr[i] = ($urandom_range(0, 2) != 0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) pops[i] = 0;
    rst_n = 1'b0;
    set_all(1'b1, 1'b0, mk(3'd4, 30'h100, 32'h0, 2'd0));
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    step();
    step();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("u%0d rst enq_ready", i), er[i], 1'b0);
      chk($sformatf("u%0d rst deq_valid", i), dv[i], 1'b0);
      chk($sformatf("u%0d rst count", i), cnt[i], 2'd0);
    end
    step();
    rst_n = 1'b1;
    set_all(1'b0, 1'b0, mk(3'd4, 30'h100, 32'h0, 2'd0));
    @(negedge clk);
    for (int i = 0; i < N; i++)
      chk($sformatf("u%0d post-rst enq_ready", i), er[i], 1'b1);

    step();
    set_all(1'b1, 1'b0, mk(3'd4, 30'h100, 32'h0, 2'd0));
    step();
    set_all(1'b1, 1'b0, mk(3'd0, 30'h104, 32'hDEADBEEF, 2'd0));
    step();
    set_all(1'b0, 1'b0, mk(3'd0, 30'h104, 32'hDEADBEEF, 2'd0));
    @(negedge clk);
    chk("u0 filled count", cnt[0], 2'd2);
    chk("u0 filled enq_ready", er[0], 1'b0);
    chk("u3 filled count", cnt[3], 2'd2);
    step();
    for (int i = 0; i < N; i++) dr[i] = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("u0 drained count", cnt[0], 2'd0);

    step();
    set_all(1'b1, 1'b0, mk(3'd4, 30'h200, 32'h0, 2'd1));
    step();
    set_all(1'b1, 1'b0, mk(3'd0, 30'h204, 32'h11, 2'd2));
    step();
    set_all(1'b1, 1'b1, mk(3'd1, 30'h208, 32'h22, 2'd3));
    @(negedge clk);
    chk("u0 full enq_ready", er[0], 1'b0);
    chk("u1 pipe enq_ready", er[1], 1'b1);
    step();
    for (int i = 0; i < N; i++) ev[i] = 1'b0;
    @(negedge clk);
    chk("u0 after deq count", cnt[0], 2'd1);
    chk("u1 pipe count", cnt[1], 2'd2);
    for (int k = 0; k < 4; k++) step();

    set_all(1'b1, 1'b1, mk(3'd4, 30'h3FFFFFFC, 32'h5, 2'd1));
    @(negedge clk);
    chk("u2 flow deq_valid", dv[2], 1'b1);
    chk("u2 flow address", db[2].address, 30'h3FFFFFFC);
    chk("u2 flow source", db[2].source, 2'd1);
    chk("u2 flow count", cnt[2], 2'd0);
    step();
    for (int i = 0; i < N; i++) ev[i] = 1'b0;
    @(negedge clk);
    chk("u2 flow after count", cnt[2], 2'd0);

    rand_cycles(120);
    for (int c = 0; c < 3; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (!ev[i] || fired[i]) eb[i] = rnd();
        ev[i] = 1'b1;
        dr[i] = 1'b0;
      end
    end
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      ev[i] = 1'b0;
      dr[i] = 1'b0;
    end
    @(negedge clk);
    chk("u3 mid-rst deq_valid", dv[3], 1'b0);
    chk("u3 mid-rst count", cnt[3], 2'd0);
    chk("u0 mid-rst deq_valid", dv[0], 1'b0);
    rand_cycles(120);

    step();
    for (int i = 0; i < N; i++) begin
      ev[i] = 1'b0;
      dr[i] = 1'b1;
    end
    for (int k = 0; k < 6; k++) step();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("u%0d final count", i), cnt[i], 2'd0);
      chk($sformatf("u%0d leftover beats", i), sb[i].size(), 0);
    end
    chk("u3 enough beats", pops[3] >= 10, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
